// File: rtl/signature_ctrl_pkg.sv
// Shared constants for the signature-analyzer sequencer: pixel/signature widths,
// default run lengths and the controller state encoding.
package signature_ctrl_pkg;

    localparam int PIXEL_WIDTH_OUT    = 8;
    localparam int MAX_PIXEL_BITS     = 16;
    localparam int DEF_FRAME_PIXELS   = 64;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // States in which a run is in flight and abort_i is honoured.
    function automatic logic state_busy(input logic [2:0] s);
        return (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/signature_ctrl_if.sv
// Bundle between the self-test sequencer and its environment (pipeline strobe,
// analyzer signature/controls, run request and results).
interface signature_ctrl_if
    import signature_ctrl_pkg::*;
#(
    parameter int SIG_W = MAX_PIXEL_BITS,
    parameter int CNT_W = $clog2(DEF_FRAME_PIXELS + 1)
);

    logic             start_i;
    logic             abort_i;
    logic             pix_valid_i;
    logic [SIG_W-1:0] golden_i;
    logic [SIG_W-1:0] signature_i;
    logic             sa_clear_o;
    logic             sa_en_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic             timeout_o;
    logic [SIG_W-1:0] signature_o;
    logic [CNT_W-1:0] pix_count_o;

    modport master (
        output start_i, abort_i, pix_valid_i, golden_i, signature_i,
        input  sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o,
               signature_o, pix_count_o
    );

    modport slave (
        input  start_i, abort_i, pix_valid_i, golden_i, signature_i,
        output sa_clear_o, sa_en_o, busy_o, done_o, pass_o, timeout_o,
               signature_o, pix_count_o
    );

endinterface

// File: rtl/signature_ctrl_timeout.sv
// Saturating idle-cycle counter for the RUN state; flags the idle cycle that
// brings the count up to TIMEOUT_CYCLES.
module signature_ctrl_timeout
    import signature_ctrl_pkg::*;
#(
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int W              = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Asserted on the increment that reaches the limit, so the caller can leave
    // RUN on that same edge.
    assign expired = inc && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!nreset || clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/signature_ctrl.sv
// Built-in self-test sequencer: clears and enables the signature analyzer for one
// frame of accepted pixels, captures the signature and compares it to golden.
module signature_ctrl
    import signature_ctrl_pkg::*;
#(
    parameter int  FRAME_PIXELS   = DEF_FRAME_PIXELS,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int CNT_W          = $clog2(FRAME_PIXELS + 1)
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    signature_ctrl_if.slave bus
);

    logic [2:0]                state;
    logic [2:0]                state_next;
    logic [CNT_W-1:0]          pix_count;
    logic [MAX_PIXEL_BITS-1:0] golden;
    logic [MAX_PIXEL_BITS-1:0] signature;
    logic                      pass;
    logic                      timeout;
    logic                      start_ok;
    logic                      last_pixel;
    logic                      idle_clear;
    logic                      idle_inc;
    logic                      idle_expired;

    assign start_ok   = (state == ST_IDLE) && bus.start_i && !bus.abort_i;
    assign last_pixel = bus.pix_valid_i && (pix_count == CNT_W'(FRAME_PIXELS - 1));
    assign idle_clear = (state != ST_RUN) || bus.pix_valid_i;
    assign idle_inc   = (state == ST_RUN) && !bus.pix_valid_i;

    signature_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk_i),
        .nreset  (nreset_i),
        .clear   (idle_clear),
        .inc     (idle_inc),
        .expired (idle_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_ok) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = ST_RUN;
            ST_RUN: begin
                if (last_pixel)        state_next = ST_CAPTURE;
                else if (idle_expired) state_next = ST_DONE;
            end
            ST_CAPTURE: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        // Abort beats every transition of an in-flight run.
        if (bus.abort_i && state_busy(state)) state_next = ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state     <= ST_IDLE;
            pix_count <= '0;
            golden    <= '0;
            signature <= '0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                golden    <= bus.golden_i;
                pix_count <= '0;
                pass      <= 1'b0;
                timeout   <= 1'b0;
            end
            if ((state == ST_RUN) && !bus.abort_i) begin
                if (bus.pix_valid_i) begin
                    pix_count <= pix_count + 1'b1;
                end else if (idle_expired) begin
                    timeout   <= 1'b1;
                    pass      <= 1'b0;
                    signature <= bus.signature_i;
                end
            end
            // Analyzer registered the last pixel on the previous edge, so its output is final here.
            if ((state == ST_CAPTURE) && !bus.abort_i) begin
                signature <= bus.signature_i;
                pass      <= (bus.signature_i == golden);
            end
        end
    end

    assign bus.sa_clear_o  = (state == ST_CLEAR);
    assign bus.sa_en_o     = (state == ST_RUN);
    assign bus.busy_o      = state_busy(state);
    assign bus.done_o      = (state == ST_DONE);
    assign bus.pass_o      = pass;
    assign bus.timeout_o   = timeout;
    assign bus.signature_o = signature;
    assign bus.pix_count_o = pix_count;

endmodule

// File: tb/tb_signature_ctrl.sv
// Bench for signature_ctrl with a stand-in rotate-xor analyzer beside it.
module tb_signature_ctrl;
    import signature_ctrl_pkg::*;

    localparam int FP = 4;
    localparam int TO = 8;
    localparam int SW = MAX_PIXEL_BITS;
    localparam int CW = $clog2(FP + 1);

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    signature_ctrl_if #(.SIG_W(SW), .CNT_W(CW)) bus ();

    signature_ctrl #(.FRAME_PIXELS(FP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .bus      (bus)
    );

    // Stand-in analyzer: rotate left by one, then xor in the pixel.
    function automatic logic [SW-1:0] absorb(input logic [SW-1:0] s, input logic [SW-1:0] p);
        return {s[SW-2:0], s[SW-1]} ^ p;
    endfunction

    logic [SW-1:0] pixel;
    logic [SW-1:0] ana_sig;
    int            ana_cnt;

    always_ff @(posedge clk) begin
        if (!nreset || bus.sa_clear_o) begin
            ana_sig <= '0;
            ana_cnt <= 0;
        end else if (bus.sa_en_o && bus.pix_valid_i) begin
            ana_sig <= absorb(ana_sig, pixel);
            ana_cnt <= ana_cnt + 1;
        end
    end
    assign bus.signature_i = ana_sig;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int            n_pix;
        int            gap;
        int            extra;
        bit            clr_pix;
        logic [SW-1:0] golden;
        int            exp_done;
        bit            exp_to;
        bit            exp_pass;
        int            exp_cnt;
        logic [SW-1:0] exp_sig;
    } vec_t;

    vec_t          vecs[7];
    bit            sched[$];
    logic [SW-1:0] spix[$];

    task automatic build_sched(input int n, input int gap, input int extra);
        sched.delete();
        spix.delete();
        for (int i = 0; i < n; i++) begin
            sched.push_back(1'b1);
            spix.push_back(SW'(i + 1));
            if (i < n - 1)
                for (int g = 0; g < gap; g++) begin
                    sched.push_back(1'b0);
                    spix.push_back('0);
                end
        end
        for (int e = 0; e < extra; e++) begin
            sched.push_back(1'b1);
            spix.push_back(SW'(16'h99));
        end
    endtask

    // Run outcome from the schedule: FP-th pixel ends the frame (done two cycles
    // later), or TO consecutive silent cycles end it (done the cycle after).
    task automatic predict(output int done_c, output bit to, output int cnt, output logic [SW-1:0] sig);
        int idle;
        bit v;
        idle = 0; to = 1'b0; cnt = 0; sig = '0; done_c = -1;
        for (int c = 0; c < 200 && done_c < 0; c++) begin
            v = (c < sched.size()) ? sched[c] : 1'b0;
            if (v) begin
                sig = absorb(sig, spix[c]);
                cnt++;
                idle = 0;
                if (cnt == FP) done_c = c + 2;
            end else begin
                idle++;
                if (idle == TO) begin
                    to = 1'b1;
                    done_c = c + 1;
                end
            end
        end
    endtask

    // Entry and exit: at a negative edge with the DUT in IDLE.
    task automatic do_run(input string tag, input logic [SW-1:0] golden, input bit clr_pix,
                          input bit rand_start, input int exp_done, input bit exp_to,
                          input bit exp_pass, input int exp_cnt, input logic [SW-1:0] exp_sig);
        int seen;
        int end_c;
        bus.start_i = 1'b1;
        bus.golden_i = golden;
        bus.pix_valid_i = 1'b0;
        @(negedge clk);
        check({tag, ".clear"}, bus.sa_clear_o, 1);
        check({tag, ".en_in_clear"}, bus.sa_en_o, 0);
        check({tag, ".busy_clear"}, bus.busy_o, 1);
        check({tag, ".pass_cleared"}, bus.pass_o, 0);
        check({tag, ".to_cleared"}, bus.timeout_o, 0);
        check({tag, ".cnt_cleared"}, bus.pix_count_o, 0);
        bus.start_i = 1'b0;
        bus.golden_i = ~golden;
        bus.pix_valid_i = clr_pix;
        pixel = SW'($urandom);
        @(negedge clk);
        seen = -1;
        end_c = exp_to ? exp_done - 1 : exp_done - 2;
        for (int c = 0; c < 300; c++) begin
            if (bus.done_o) begin
                seen = c;
                break;
            end
            check({tag, ".en"}, bus.sa_en_o, (c <= end_c));
            check({tag, ".busy"}, bus.busy_o, 1);
            bus.pix_valid_i = (c < sched.size()) ? sched[c] : 1'b0;
            pixel = (c < spix.size()) ? spix[c] : SW'($urandom);
            bus.start_i = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        check({tag, ".done_cycle"}, seen, exp_done);
        bus.pix_valid_i = 1'b0;
        bus.start_i = 1'b0;
        if (seen < 0) begin
            nreset = 1'b0;
            @(negedge clk);
            nreset = 1'b1;
            @(negedge clk);
            return;
        end
        check({tag, ".busy_done"}, bus.busy_o, 0);
        check({tag, ".timeout"}, bus.timeout_o, exp_to);
        check({tag, ".pass"}, bus.pass_o, exp_pass);
        check({tag, ".sig"}, bus.signature_o, exp_sig);
        check({tag, ".count"}, bus.pix_count_o, exp_cnt);
        check({tag, ".absorbed"}, ana_cnt, exp_cnt);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.done_o, 0);
        check({tag, ".pass_sticky"}, bus.pass_o, exp_pass);
    endtask

    task automatic run_row(input int i);
        build_sched(vecs[i].n_pix, vecs[i].gap, vecs[i].extra);
        do_run($sformatf("row%0d", i), vecs[i].golden, vecs[i].clr_pix, 1'b0, vecs[i].exp_done,
               vecs[i].exp_to, vecs[i].exp_pass, vecs[i].exp_cnt, vecs[i].exp_sig);
    endtask

    // Start, absorb two pixels, leave the DUT in the third RUN cycle.
    task automatic start_two_pixels();
        bus.start_i = 1'b1;
        bus.golden_i = SW'(16'h02);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.pix_valid_i = 1'b1;
        pixel = SW'(1);
        @(negedge clk);
        pixel = SW'(2);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int busys;
        //          n  gap ext clr golden  done to pass cnt sig
        vecs[0] = '{4, 0, 0, 0, SW'(16'h02), 5,  0, 1, 4, SW'(16'h02)};
        vecs[1] = '{4, 3, 0, 1, SW'(16'h05), 14, 0, 0, 4, SW'(16'h02)};
        vecs[2] = '{4, 0, 1, 0, SW'(16'h02), 5,  0, 1, 4, SW'(16'h02)};
        vecs[3] = '{2, 0, 0, 0, SW'(16'h00), 10, 1, 0, 2, SW'(16'h00)};
        vecs[4] = '{0, 0, 0, 0, SW'(16'h00), 8,  1, 0, 0, SW'(16'h00)};
        vecs[5] = '{4, 7, 0, 0, SW'(16'h02), 26, 0, 1, 4, SW'(16'h02)};
        vecs[6] = '{2, 8, 0, 0, SW'(16'h01), 9,  1, 0, 1, SW'(16'h01)};

        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.pix_valid_i = 1'b0;
        bus.golden_i = '0;
        pixel = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("rst.sa_clear", bus.sa_clear_o, 0);
        check("rst.sa_en", bus.sa_en_o, 0);
        check("rst.busy", bus.busy_o, 0);
        check("rst.done", bus.done_o, 0);
        check("rst.pass", bus.pass_o, 0);
        check("rst.timeout", bus.timeout_o, 0);
        check("rst.sig", bus.signature_o, 0);
        check("rst.count", bus.pix_count_o, 0);

        for (int i = 0; i < 7; i++) run_row(i);

        // Abort in RUN after two pixels, with start also raised.
        run_row(0);
        start_two_pixels();
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        check("abort.busy", bus.busy_o, 0);
        check("abort.done", bus.done_o, 0);
        check("abort.sa_en", bus.sa_en_o, 0);
        check("abort.pass", bus.pass_o, 0);
        check("abort.timeout", bus.timeout_o, 0);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        bus.pix_valid_i = 1'b0;
        dones = 0;
        busys = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            dones += int'(bus.done_o);
            busys += int'(bus.busy_o);
        end
        check("abort.no_done_after", dones, 0);
        check("abort.idle_after", busys, 0);

        // abort with start in IDLE: start ignored.
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        @(negedge clk);
        check("idle_abort.busy", bus.busy_o, 0);
        check("idle_abort.sa_clear", bus.sa_clear_o, 0);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("idle_abort.still_idle", bus.busy_o, 0);

        // Reset mid-run, then a clean passing run.
        run_row(0);
        start_two_pixels();
        bus.pix_valid_i = 1'b0;
        nreset = 1'b0;
        @(negedge clk);
        check("midrst.sa_clear", bus.sa_clear_o, 0);
        check("midrst.sa_en", bus.sa_en_o, 0);
        check("midrst.busy", bus.busy_o, 0);
        check("midrst.done", bus.done_o, 0);
        check("midrst.pass", bus.pass_o, 0);
        check("midrst.sig", bus.signature_o, 0);
        check("midrst.count", bus.pix_count_o, 0);
        nreset = 1'b1;
        @(negedge clk);
        run_row(0);

        for (int r = 0; r < 40; r++) begin
            int            dens;
            int            len;
            int            dc;
            int            cnt;
            bit            to;
            bit            match;
            logic [SW-1:0] sig;
            dens = $urandom_range(20, 95);
            len  = $urandom_range(1, 40);
            sched.delete();
            spix.delete();
            for (int i = 0; i < len; i++) begin
                sched.push_back($urandom_range(0, 99) < dens);
                spix.push_back(SW'($urandom));
            end
            predict(dc, to, cnt, sig);
            match = 1'($urandom_range(0, 1));
            do_run($sformatf("rnd%0d", r),
                   match ? sig : sig ^ SW'(1 << $urandom_range(0, SW - 1)),
                   1'($urandom_range(0, 1)), 1'b1, dc, to, match && !to, cnt, sig);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
